// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the ALU execute block.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents:
//   ALU_* opcode constants  - 4-bit operation codes from the ALU control decoder
//   alu_state_e             - execute-block FSM states
//   op_is_mul()             - selects the iterative multiplier path
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;  // CBZ: test B against zero
    localparam logic [3:0] ALU_MOVZ  = 4'b1000;  // MOVZ: immediate passes through B
    localparam logic [3:0] ALU_MUL   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    function automatic logic op_is_mul(input logic [3:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low N bits kept.
// Latency: bit 0 is consumed on the start edge, bit N-1 on the edge where done is high (N edges total).
// Backpressure: none; the caller must not pulse start while an operation is in flight.
//
// Ports:
//   clk, reset     - clock, synchronous active-low reset (aborts any operation)
//   start          - begin a multiply with operands a, b (one-cycle pulse)
//   a, b           - multiplicand / multiplier, sampled only when start is high
//   done           - combinational, high in the cycle whose clock edge finishes the last bit
//   product        - low N bits of a*b, valid while done is high
module mul_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          busy_q,   busy_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [N-1:0]  acc_q,    acc_d;     // partial product
    logic [N-1:0]  mcand_q,  mcand_d;   // multiplicand, shifted left each bit
    logic [N-1:0]  mplier_q, mplier_d;  // multiplier, shifted right each bit

    logic [N-1:0]  addend;
    logic [N-1:0]  sum;

    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = acc_q + addend;

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = 1'b0;
        product  = sum;

        if (start) begin
            // Bit 0 is handled directly from the inputs so the whole multiply
            // fits in N edges including the start edge.
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                done   = 1'b1;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith ops plus an iterative N-cycle multiply, one op in flight.
// Latency: 1 cycle for single-cycle ops, N cycles for MUL (acceptance edge to out_valid).
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, no same-cycle bypass.
//
// Ports:
//   clk, reset            - clock, synchronous active-low reset (aborts and discards any op)
//   in_valid / in_ready   - request handshake; alucontrol, a, b captured on acceptance
//   alucontrol            - 4-bit opcode (see alu_pkg)
//   a, b                  - N-bit operands
//   out_valid / out_ready - result handshake
//   result, zero          - registered result and its result==0 flag
module alu_exec #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    import alu_pkg::*;

    alu_state_e   state_q,     state_d;
    logic         in_ready_q,  in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] result_q,    result_d;
    logic         zero_q,      zero_d;

    logic         accept;
    logic         mul_start;
    logic         mul_done;
    logic [N-1:0] mul_product;
    logic [N-1:0] alu_res;

    // in_ready_q is high exactly in IDLE, so it doubles as the acceptance gate.
    assign accept    = in_valid && in_ready_q;
    assign mul_start = accept && op_is_mul(alucontrol);

    mul_iter #(
        .N(N)
    ) u_mul_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath. Unknown opcodes yield zero (and so zero=1).
    always_comb begin
        alu_res = '0;
        case (alucontrol)
            ALU_AND:   alu_res = a & b;
            ALU_OR:    alu_res = a | b;
            ALU_ADD:   alu_res = a + b;
            ALU_SUB:   alu_res = a - b;
            ALU_PASSB: alu_res = b;
            ALU_MOVZ:  alu_res = b;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (op_is_mul(alucontrol)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d     = ST_HOLD;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d     = ST_HOLD;
                    result_d    = mul_product;
                    zero_d      = (mul_product == '0);
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Returning to IDLE (not straight to a new accept) is what
                // enforces the no-bypass rule.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter N, default 64: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-004 in_valid  input  1  request present on alucontrol/a/b.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alucontrol  input  4  operation code from the ALU control decoder.
REQ-007 a  input  N  operand A (register file read 1).
REQ-008 b  input  N  operand B (register file read 2 or sign-extended immediate).
REQ-009 out_valid  output  1  result/zero valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  N  operation result.
REQ-012 zero  output  1  high when result == 0.

Function
REQ-013 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 pass B (CBZ), 1000 pass B (MOVZ path), 1100 MUL (low N bits of a*b, unsigned).
REQ-014 Any other opcode: result = 0, zero = 1, completes as a single-cycle op.
REQ-015 ADD/SUB/MUL wrap modulo 2^N; no carry, overflow or high-product output.
REQ-016 FSM states IDLE, BUSY, HOLD; in_ready = 1 only in IDLE.
REQ-017 Acceptance = in_valid && in_ready at a rising edge; a, b and alucontrol are captured then; later input changes are ignored.
REQ-018 Non-MUL op: IDLE -> HOLD at the accepting edge; result/zero registered at that edge; out_valid high from the next cycle (latency 1).
REQ-019 MUL: IDLE -> BUSY at the accepting edge; iterative shift-add, one multiplier bit per cycle, LSB first, 6-bit (log2 N) iteration counter.
REQ-020 BUSY -> HOLD at the edge completing iteration N-1; out_valid high exactly N cycles after acceptance.
REQ-021 HOLD: out_valid, result and zero held stable until out_valid && out_ready; at that edge -> IDLE and out_valid = 0.
REQ-022 No bypass: a new request cannot be accepted in the cycle the result is consumed; peak throughput one single-cycle op per 2 cycles.
REQ-023 out_ready is ignored outside HOLD; in_valid is ignored outside IDLE.
REQ-024 zero is registered together with result, never combinational from inputs.

Reset
REQ-025 On reset: state = IDLE, out_valid = 0, result = 0, zero = 0, iteration counter = 0, partial product = 0.
REQ-026 Reset while in BUSY or HOLD aborts the operation; the pending result is discarded, never presented.
REQ-027 in_ready = 1 from the first cycle after reset is released.

Structure
REQ-028 Opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MOVZ, ALU_MUL) and the FSM state enum are defined in package alu_pkg; the decoder and this block share it.
REQ-029 Iterative multiplier is sub-module mul_iter (start, a, b -> done, product), N-parameterised, same clk/reset.
REQ-030 Single-cycle datapath is combinational inside alu_exec, registered into the result register.

Verification
REQ-031 ADD a=5, b=7, out_ready=1 -> out_valid next cycle, result=12, zero=0; SUB 7-7 -> result=0, zero=1.
REQ-032 SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF; ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1.
REQ-033 MUL a=3, b=0x10 -> in_ready=0 for 64 cycles, out_valid exactly 64 cycles after acceptance, result=0x30; MUL a=2^63, b=2 -> result=0, zero=1.
REQ-034 AND 0xF0F0 & 0xFF00 -> 0xF000 with out_ready=0 for 5 cycles -> result/out_valid stable, in_ready=0; consumed on cycle 6, in_ready=1 next cycle.
REQ-035 Start MUL, assert reset=0 at iteration 20 -> next cycle out_valid=0, result=0, in_ready=1 after release; no stale result ever appears.
REQ-036 Opcode 0101 with a=b=0xFF -> result=0, zero=1, latency 1; then opcode 0111, b=0 -> result=0, zero=1 (CBZ taken).
